// File: rtl/tnn_neuron_stream_pkg.sv
// rtl/tnn_neuron_stream_pkg.sv - shared types and width helper for the TNN neuron blocks
package tnn_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} tnn_state_t;

  // Ternary weight code; both mask bits set collapses to zero weight.
  typedef enum logic [1:0] {W_ZERO = 2'b00, W_POS = 2'b01, W_NEG = 2'b10} tnn_weight_t;

  // Signed accumulator width that holds +/- NUM_IN full-scale activations.
  function automatic int acc_width(input int num_in, input int in_w);
    return $clog2(num_in * (2 ** in_w - 1) + 1) + 1;
  endfunction

  function automatic tnn_weight_t weight_code(input logic pos, input logic neg);
    if (pos && !neg) return W_POS;
    if (neg && !pos) return W_NEG;
    return W_ZERO;
  endfunction

endpackage

// File: rtl/tnn_neuron_stream_if.sv
// rtl/tnn_neuron_stream_if.sv - activation-in / decision-out stream bundle (TNN_SCORE_OUT_EN adds out_score)
interface tnn_neuron_stream_if #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;
`ifdef TNN_SCORE_OUT_EN
  logic signed [ACC_W-1:0] out_score;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
`ifdef TNN_SCORE_OUT_EN
    input  out_score,
`endif
    input  out_bit
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
`ifdef TNN_SCORE_OUT_EN
    output out_score,
`endif
    output out_bit
  );
endinterface

// File: rtl/tnn_neuron_stream_ternary_mac.sv
// rtl/tnn_neuron_stream_ternary_mac.sv - combinational ternary multiply-accumulate step
module tnn_ternary_mac
  import tnn_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int ACC_W = 5
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [IN_W-1:0]  in_data,
  input  logic                    pos,
  input  logic                    neg,
  output logic signed [ACC_W-1:0] acc_next
);
  // Activation is unsigned, so zero-extend before the signed add/subtract.
  logic signed [ACC_W-1:0] ext;
  assign ext = signed'({{(ACC_W - IN_W){1'b0}}, in_data});

  // Apply the weight: add, subtract, or pass the accumulator through.
  always_comb begin
    acc_next = acc;
    case (weight_code(pos, neg))
      W_POS:   acc_next = acc + ext;
      W_NEG:   acc_next = acc - ext;
      default: acc_next = acc;
    endcase
  end
endmodule

// File: rtl/tnn_neuron_stream.sv
// rtl/tnn_neuron_stream.sv - sequential ternary neuron over a beat stream (TNN_SCORE_OUT_EN adds out_score)
module tnn_neuron_stream
  import tnn_pkg::*;
#(
  parameter int                NUM_IN   = 4,
  parameter int                IN_W     = 2,
  parameter logic [NUM_IN-1:0] POS_MASK = 4'b0111,
  parameter logic [NUM_IN-1:0] NEG_MASK = 4'b1000,
  parameter int                THRESH   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  tnn_neuron_stream_if.slave  s,
  output logic                busy
);
  localparam int ACC_W = acc_width(NUM_IN, IN_W);
  localparam int IDX_W = $clog2(NUM_IN);
  localparam logic signed [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  tnn_state_t              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [IDX_W-1:0]        idx;
  logic                    accept;

  assign accept = s.in_valid && s.in_ready;

  tnn_ternary_mac #(.IN_W(IN_W), .ACC_W(ACC_W)) u_mac (
    .acc      (acc),
    .in_data  (s.in_data),
    .pos      (POS_MASK[idx]),
    .neg      (NEG_MASK[idx]),
    .acc_next (acc_sum)
  );

  // Control FSM with registered handshake outputs; rst beats abort beats everything else.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= ST_IDLE;
      acc         <= '0;
      idx         <= '0;
      s.in_ready  <= 1'b1;
      s.out_valid <= 1'b0;
      busy        <= 1'b0;
      if (rst) begin
        s.out_bit <= 1'b0;
`ifdef TNN_SCORE_OUT_EN
        s.out_score <= '0;
`endif
      end
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            acc  <= acc_sum;
            busy <= 1'b1;
            if (idx == LAST_IDX) begin
              state       <= ST_DONE;
              idx         <= '0;
              s.in_ready  <= 1'b0;
              s.out_valid <= 1'b1;
              s.out_bit   <= (acc_sum >= THRESH_V);
`ifdef TNN_SCORE_OUT_EN
              s.out_score <= acc_sum;
`endif
            end else begin
              state <= ST_ACC;
              idx   <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (s.out_ready) begin
            state       <= ST_IDLE;
            acc         <= '0;
            idx         <= '0;
            s.in_ready  <= 1'b1;
            s.out_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
